// File: rtl/skid_buffer_full_reg.sv
// skid_buffer_full_reg
//   Two-entry valid/ready register slice. Every output (data_valid_o,
//   data_o, data_ready_o) comes straight from a flop, so both the forward
//   valid/data path and the backward ready path are cut. Sustains one
//   transfer per cycle with one cycle of forward latency.
//
//   Storage: main register (drives data_o) and skid register (holds the
//   one extra word accepted in the cycle downstream stalls).
//
// Parameters:
//   DATA_SIZE     payload width in bits (min 1)
//
// Ports:
//   clk_i         clock, all logic on rising edge
//   rst_clk_i     synchronous active-high reset
//   data_i        upstream payload
//   data_valid_i  upstream valid
//   data_ready_o  registered ready to upstream
//   data_o        registered payload to downstream
//   data_valid_o  registered valid to downstream
//   data_ready_i  downstream ready
//   stall_cnt_o   (only with SKID_BUFFER_FULL_REG_STALL_CNT_EN) saturating
//                 16-bit count of cycles with data_valid_o && !data_ready_i
//
// Optional feature macro: SKID_BUFFER_FULL_REG_STALL_CNT_EN

module skid_buffer_full_reg #(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_clk_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i
`ifdef SKID_BUFFER_FULL_REG_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_SIZE-1:0]   main_q, main_d;
  logic [DATA_SIZE-1:0]   skid_q, skid_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic                   in_fire;
  logic                   out_fire;

  // Handshakes use the registered outputs, so no input reaches an output
  // combinationally.
  always_comb begin
    in_fire  = data_valid_i && ready_q;
    out_fire = valid_q && data_ready_i;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StBusy;
          main_d  = data_i;
        end
      end
      StBusy: begin
        unique case ({in_fire, out_fire})
          2'b11: main_d = data_i;
          2'b10: begin
            state_d = StFull;
            skid_d  = data_i;
          end
          2'b01: state_d = StEmpty;
          default: ;
        endcase
      end
      StFull: begin
        // ready_q is low here, so no upstream word can arrive.
        if (out_fire) begin
          state_d = StBusy;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Outputs are registered copies of functions of the next state, which
    // makes them equal to functions of the current state after the edge.
    valid_d = (state_d != StEmpty);
    ready_d = (state_d != StFull);
  end

  // ready_q resets to 0 so upstream sees no ready while reset is held; it
  // rises one edge after reset releases.
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign data_o       = main_q;
  assign data_valid_o = valid_q;
  assign data_ready_o = ready_q;

`ifdef SKID_BUFFER_FULL_REG_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !data_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skid_buffer_full_reg.sv
// Directed testbench for skid_buffer_full_reg (DATA_SIZE = 8).
// Inputs change 1 ns after each rising edge; outputs are checked there too.

module tb_skid_buffer_full_reg;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         vin;
  logic         rdy_o;
  logic [W-1:0] dout;
  logic         vout;
  logic         rdy_i;
`ifdef SKID_BUFFER_FULL_REG_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  skid_buffer_full_reg #(.DATA_SIZE(W)) dut (
    .clk_i        (clk),
    .rst_clk_i    (rst),
    .data_i       (din),
    .data_valid_i (vin),
    .data_ready_o (rdy_o),
    .data_o       (dout),
    .data_valid_o (vout),
    .data_ready_i (rdy_i)
`ifdef SKID_BUFFER_FULL_REG_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a word and check outputs after the edge: one-cycle latency.
  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d,
                         input logic r);
    check_eq({tag, "_valid"}, {31'd0, vout}, {31'd0, v});
    check_eq({tag, "_data"},  {24'd0, dout}, {24'd0, d});
    check_eq({tag, "_ready"}, {31'd0, rdy_o}, {31'd0, r});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    din   = '0;
    vin   = 1'b0;
    rdy_i = 1'b1;

    // Reset then idle
    repeat (3) tick();
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    check_eq("rst_rel_ready_pre", {31'd0, rdy_o}, 32'd0);
    tick();
    chk_out("rst_rel", 1'b0, 8'h00, 1'b1);

    // Streaming 01..10 with downstream always ready
    for (int i = 1; i <= 16; i++) begin
      din = 8'(i);
      vin = 1'b1;
      check_eq("stream_ready_in", {31'd0, rdy_o}, 32'd1);
      tick();
      chk_out("stream", 1'b1, 8'(i), 1'b1);
    end
    vin = 1'b0;
    din = 8'hEE;
    tick();
    check_eq("stream_end_valid", {31'd0, vout}, 32'd0);

    // Backpressure: A0 appears, downstream stalls, A1 lands in skid
    din = 8'hA0; vin = 1'b1;
    tick();
    chk_out("bp_a0", 1'b1, 8'hA0, 1'b1);
    rdy_i = 1'b0; din = 8'hA1;
    tick();
    chk_out("bp_full", 1'b1, 8'hA0, 1'b0);
    din = 8'hA2;
    tick();
    chk_out("bp_hold", 1'b1, 8'hA0, 1'b0);
    rdy_i = 1'b1;
    tick();
    chk_out("bp_a1", 1'b1, 8'hA1, 1'b1);
    tick();
    chk_out("bp_a2", 1'b1, 8'hA2, 1'b1);
    vin = 1'b0; din = 8'h00;
    tick();
    check_eq("bp_empty_valid", {31'd0, vout}, 32'd0);

    // Full drain with no new input
    din = 8'hA0; vin = 1'b1;
    tick();
    rdy_i = 1'b0; din = 8'hA1;
    tick();
    chk_out("drain_full", 1'b1, 8'hA0, 1'b0);
    vin = 1'b0; din = 8'hFF; rdy_i = 1'b1;
    tick();
    chk_out("drain_a1", 1'b1, 8'hA1, 1'b1);
    tick();
    chk_out("drain_empty", 1'b0, 8'hA1, 1'b1);

    // Reset while full, upstream still presenting data
    din = 8'hB0; vin = 1'b1;
    tick();
    rdy_i = 1'b0; din = 8'hB1;
    tick();
    chk_out("rfull_pre", 1'b1, 8'hB0, 1'b0);
    rst = 1'b1; rdy_i = 1'b1;
    tick();
    chk_out("rfull_rst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0; vin = 1'b0;
    tick();
    chk_out("rfull_rel", 1'b0, 8'h00, 1'b1);
    din = 8'h55; vin = 1'b1;
    tick();
    chk_out("rfull_55", 1'b1, 8'h55, 1'b1);
    vin = 1'b0; din = 8'h00;
    tick();
    check_eq("rfull_no_stale", {31'd0, vout}, 32'd0);

`ifdef SKID_BUFFER_FULL_REG_STALL_CNT_EN
    check_eq("stall_zero", {16'd0, stall_cnt}, 32'd0);
    din = 8'h11; vin = 1'b1; rdy_i = 1'b0;
    tick();
    vin = 1'b0;
    check_eq("stall_start", {16'd0, stall_cnt}, 32'd0);
    repeat (5) tick();
    check_eq("stall_5", {16'd0, stall_cnt}, 32'd5);
    rst = 1'b1;
    tick();
    check_eq("stall_rst", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    din = 8'h22; vin = 1'b1;
    tick();
    vin = 1'b0;
    repeat (70000) tick();
    check_eq("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    rdy_i = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/skid_buffer_full_reg.md
Name: skid_buffer_full_reg

Overview:
Two-entry valid/ready register slice that registers all three outputs: data_valid_o, data_o and data_ready_o.
- Complements the existing fall-through skid buffer, which registers only the data held during a stall. This block cuts the backward ready path as well.
- Placed between pipeline stages where data_ready_i timing fails, or where both directions need a flop boundary.
- Sustains one transfer per cycle with one cycle of forward latency.

Parameters:
DATA_SIZE, 8, width of data_i/data_o in bits (min 1)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_clk_i  input  1  synchronous active-high reset
data_i  input  DATA_SIZE  upstream payload
data_valid_i  input  1  upstream valid
data_ready_o  output  1  registered ready to upstream
data_o  output  DATA_SIZE  registered payload to downstream
data_valid_o  output  1  registered valid to downstream
data_ready_i  input  1  downstream ready

Behaviour:
- Interface: one clock (clk_i); reset rst_clk_i is synchronous and active-high. No asynchronous logic.
- Handshakes:
  - Upstream transfer (in_fire) = data_valid_i && data_ready_o.
  - Downstream transfer (out_fire) = data_valid_o && data_ready_i.
- Storage: main register (drives data_o) and skid register.
- States: StEmpty (0 entries), StBusy (1 entry in main), StFull (main + skid).
- Outputs are pure functions of registered state:
  - StEmpty: valid_o=0, ready_o=1.
  - StBusy: valid_o=1, ready_o=1.
  - StFull: valid_o=1, ready_o=0.
- No combinational path from any input to any output.
- Transitions:
  - StEmpty: in_fire -> StBusy, main<=data_i; else stay.
  - StBusy, in_fire && out_fire -> StBusy, main<=data_i.
  - StBusy, in_fire && !out_fire -> StFull, skid<=data_i, main held.
  - StBusy, !in_fire && out_fire -> StEmpty.
  - StBusy, neither -> hold.
  - StFull: out_fire -> StBusy, main<=skid. in_fire is impossible because ready_o=0. Otherwise hold.
- Latency: a word accepted at edge N is presented on data_o with valid_o=1 from edge N onward, i.e. visible in cycle N+1.
- Throughput: 1 word/cycle when data_ready_i stays high.
- Stall stability: while valid_o=1 && ready_i=0, data_o and valid_o hold unchanged.
- Ordering: strict FIFO. No drop, no duplication.
- data_ready_i falling while upstream streams: exactly one extra word is absorbed into skid, then ready_o drops the following cycle.
- Reset (rst_clk_i=1 at an edge):
  - state<=StEmpty, main<=0, skid<=0.
  - data_valid_o=0 and data_o=0 after the edge.
  - data_ready_o=0 while rst_clk_i is high; 1 on the first cycle after reset deasserts.
- Reset mid-operation: all held words are discarded, including in StFull. Reset takes priority over simultaneous fires.
- data_i is ignored when data_valid_i=0. No X propagation into storage on non-fire cycles.

Optional Feature:
Macro SKID_BUFFER_FULL_REG_STALL_CNT_EN
- Defined:
  - Adds output port stall_cnt_o, 16 bits.
  - Counts cycles where data_valid_o && !data_ready_i (downstream backpressure).
  - Saturates at 16'hFFFF and resets to 0.
  - Registered, so the value reflects stalls up to the previous edge.
- Undefined: the port and counter are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst_clk_i=1 for 3 cycles -> valid_o=0, data_o=0, ready_o=0. After release -> ready_o=1 next cycle, valid_o stays 0.
- Streaming, DATA_SIZE=8, ready_i=1: send 8'h01..8'h10 back-to-back -> data_o shows 8'h01..8'h10 in order, one cycle after each acceptance, no bubbles, ready_o never drops.
- Backpressure:
  - Stimulus: stream 8'hA0,A1,A2,...; ready_i=0 from the cycle A0 appears on data_o.
  - Expected: A1 captured in skid, ready_o=0 the next cycle, data_o held at A0.
  - Then raise ready_i: A0, A1, A2... delivered in order with no loss.
- Full drain: reach StFull (A0 main, A1 skid), hold data_valid_i=0, ready_i=1 for 2 cycles -> A0 then A1 out, then valid_o=0, state StEmpty.
- Reset in StFull: assert reset with 2 words held -> next cycle valid_o=0, data_o=0. Post-reset stream 8'h55 -> only 8'h55 appears, no stale data.
- With SKID_BUFFER_FULL_REG_STALL_CNT_EN: hold one word with ready_i=0 for 5 cycles -> stall_cnt_o=5. Reset -> 0. Force 70000 stall cycles -> stall_cnt_o=16'hFFFF.
